// File: rtl/exec_issue_queue_pkg.sv
// Shared widths, operand/entry structs and the CDB snoop helper for exec_issue_queue.
// No logic of its own; latency and backpressure are defined by the modules importing it.
// Struct field widths follow the constants below.
package exec_issue_queue_pkg;

    localparam int DATA_W    = 32;
    localparam int TAG_W     = 6;
    localparam int PAYLOAD_W = 45;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              vld;
        logic [TAG_W-1:0]  tag;
    } operand_t;

    typedef struct packed {
        operand_t             rs1;
        operand_t             rs2;
        logic [PAYLOAD_W-1:0] payload;
        logic                 occ;
    } entry_t;

    // Capture CDB data into a still-waiting operand; valid operands are never touched.
    function automatic operand_t snoop(input operand_t op, input logic cdb_valid,
                                       input logic [TAG_W-1:0] cdb_tag,
                                       input logic [DATA_W-1:0] cdb_data);
        snoop = op;
        if (cdb_valid && !op.vld && (op.tag == cdb_tag)) begin
            snoop.data = cdb_data;
            snoop.vld  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/exec_iq_entry.sv
// One issue-queue slot: load, clear and CDB capture (load-time CDB bypass if EXEC_ISSUE_QUEUE_WAKEUP_BYPASS_EN).
// Latency: load and wakeup are visible one edge after the request.
// Backpressure: none here; the parent decides when to load or clear.
module exec_iq_entry
    import exec_issue_queue_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  entry_t            i_load_entry,
    input  logic              i_clear,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output entry_t            o_entry
);

    entry_t load_val;

    always_comb begin
        load_val = i_load_entry;
`ifdef EXEC_ISSUE_QUEUE_WAKEUP_BYPASS_EN
        load_val.rs1 = snoop(i_load_entry.rs1, i_cdb_valid, i_cdb_tag, i_cdb_data);
        load_val.rs2 = snoop(i_load_entry.rs2, i_cdb_valid, i_cdb_tag, i_cdb_data);
`endif
    end

    // Load wins over clear so a full queue can replace its head slot in one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_entry <= '0;
        end else if (i_flush) begin
            o_entry.occ     <= 1'b0;
            o_entry.rs1.vld <= 1'b0;
            o_entry.rs2.vld <= 1'b0;
        end else if (i_load) begin
            o_entry <= load_val;
        end else if (i_clear) begin
            o_entry.occ <= 1'b0;
        end else if (o_entry.occ) begin
            o_entry.rs1 <= snoop(o_entry.rs1, i_cdb_valid, i_cdb_tag, i_cdb_data);
            o_entry.rs2 <= snoop(o_entry.rs2, i_cdb_valid, i_cdb_tag, i_cdb_data);
        end
    end

endmodule

// File: rtl/exec_issue_queue.sv
// In-order issue queue with CDB wakeup; optional push-time bypass via EXEC_ISSUE_QUEUE_WAKEUP_BYPASS_EN.
// Latency: push visible at head after one edge; head outputs are combinational from registered state.
// Backpressure: push dropped when full unless a pop is accepted in the same cycle; pop only when head ready.
module exec_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = exec_issue_queue_pkg::DATA_W,
    parameter int TAG_W     = exec_issue_queue_pkg::TAG_W,
    parameter int PAYLOAD_W = exec_issue_queue_pkg::PAYLOAD_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [PAYLOAD_W-1:0]       i_wr_payload,
    input  logic [DATA_W-1:0]          i_wr_rs1_data,
    input  logic [DATA_W-1:0]          i_wr_rs2_data,
    input  logic                       i_wr_rs1_vld,
    input  logic                       i_wr_rs2_vld,
    input  logic [TAG_W-1:0]           i_wr_rs1_tag,
    input  logic [TAG_W-1:0]           i_wr_rs2_tag,
    input  logic                       i_rd_en,
    output logic [PAYLOAD_W-1:0]       o_rd_payload,
    output logic [DATA_W-1:0]          o_rd_rs1_data,
    output logic [DATA_W-1:0]          o_rd_rs2_data,
    output logic                       o_head_ready,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    input  logic                       i_cdb_valid,
    input  logic [TAG_W-1:0]           i_cdb_tag,
    input  logic [DATA_W-1:0]          i_cdb_data
);

    import exec_issue_queue_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             push, pop;
    entry_t           wr_entry;
    entry_t           head;
    entry_t           entries [DEPTH];
    logic             unused_bits;

    assign wr_idx  = wr_ptr[IDX_W-1:0];
    assign rd_idx  = rd_ptr[IDX_W-1:0];
    assign o_count = count;
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);

    assign head         = entries[rd_idx];
    assign o_head_ready = !o_empty && head.occ && head.rs1.vld && head.rs2.vld;
    assign o_rd_payload  = o_empty ? '0 : head.payload;
    assign o_rd_rs1_data = o_empty ? '0 : head.rs1.data;
    assign o_rd_rs2_data = o_empty ? '0 : head.rs2.data;

    assign pop  = i_rd_en && o_head_ready;
    assign push = i_wr_en && (!o_full || pop);

    always_comb begin
        wr_entry         = '0;
        wr_entry.rs1     = '{data: i_wr_rs1_data, vld: i_wr_rs1_vld, tag: i_wr_rs1_tag};
        wr_entry.rs2     = '{data: i_wr_rs2_data, vld: i_wr_rs2_vld, tag: i_wr_rs2_tag};
        wr_entry.payload = i_wr_payload;
        wr_entry.occ     = 1'b1;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        exec_iq_entry u_entry (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_flush      (i_flush),
            .i_load       (push && (wr_idx == IDX_W'(g))),
            .i_load_entry (wr_entry),
            .i_clear      (pop && (rd_idx == IDX_W'(g))),
            .i_cdb_valid  (i_cdb_valid),
            .i_cdb_tag    (i_cdb_tag),
            .i_cdb_data   (i_cdb_data),
            .o_entry      (entries[g])
        );
    end

    // Pointer MSBs only disambiguate wrap; full/empty come from the count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign unused_bits = ^{wr_ptr[PTR_W-1], rd_ptr[PTR_W-1], head.rs1.tag, head.rs2.tag};

endmodule
